// File: rtl/ogfx_lcd_refresh_if.sv
// Frame-refresh handshake (backend side) and LCD write bus for ogfx_lcd_refresh.
// The slave modport is the refresh engine; master is whoever drives it.
interface ogfx_lcd_refresh_if;
  logic        refresh_start_i;
  logic [16:0] display_size_i;
  logic [3:0]  cfg_wr_cycle_i;
  logic [15:0] refresh_data_i;
  logic        refresh_data_ready_i;
  logic        refresh_active_o;
  logic        refresh_data_request_o;
  logic        refresh_done_o;
  logic        lcd_cs_n_o;
  logic        lcd_rs_o;
  logic        lcd_wr_n_o;
  logic [15:0] lcd_d_o;

  modport slave (
    input  refresh_start_i, display_size_i, cfg_wr_cycle_i,
           refresh_data_i, refresh_data_ready_i,
    output refresh_active_o, refresh_data_request_o, refresh_done_o,
           lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_d_o
  );

  modport master (
    output refresh_start_i, display_size_i, cfg_wr_cycle_i,
           refresh_data_i, refresh_data_ready_i,
    input  refresh_active_o, refresh_data_request_o, refresh_done_o,
           lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_d_o
  );
endinterface

// File: rtl/ogfx_lcd_refresh.sv
// Full-frame LCD refresh engine: one 0x2C memory-write command, then one strobed
// data write per pixel fetched from the backend. OGFX_LCD_TE_SYNC_EN adds tearing-effect sync.
module ogfx_lcd_refresh (
  input  logic                  mclk,
  input  logic                  puc_rst_n,
`ifdef OGFX_LCD_TE_SYNC_EN
  input  logic                  lcd_te_i,
`endif
  ogfx_lcd_refresh_if.slave     bus
);

  localparam logic [15:0] CMD_RAMWR = 16'h002C;

  typedef enum logic [3:0] {
    IDLE,
`ifdef OGFX_LCD_TE_SYNC_EN
    TE_WAIT,
`endif
    CMD_LO,
    CMD_HI,
    REQ,
    WAIT_DATA,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] size_q, size_d;
  logic [16:0] pix_cnt_q, pix_cnt_d;
  logic [3:0]  phase_q, phase_d;
  logic [15:0] lcd_d_q, lcd_d_d;
  logic [16:0] pix_cnt_inc;
  logic [3:0]  phase_len;

  logic        active_c, request_c, done_c, cs_n_c, rs_c, wr_n_c;

  // Phase counter holds remaining cycles minus one; a zero setting behaves as one.
  assign phase_len   = (bus.cfg_wr_cycle_i == 4'd0) ? 4'd0 : bus.cfg_wr_cycle_i - 4'd1;
  assign pix_cnt_inc = pix_cnt_q + 17'd1;

`ifdef OGFX_LCD_TE_SYNC_EN
  logic te_meta_q, te_sync_q, te_prev_q;
  logic te_rise;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      te_meta_q <= 1'b0;
      te_sync_q <= 1'b0;
      te_prev_q <= 1'b0;
    end else begin
      te_meta_q <= lcd_te_i;
      te_sync_q <= te_meta_q;
      te_prev_q <= te_sync_q;
    end
  end

  assign te_rise = te_sync_q & ~te_prev_q;
`endif

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q   <= IDLE;
      size_q    <= '0;
      pix_cnt_q <= '0;
      phase_q   <= '0;
      lcd_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      pix_cnt_q <= pix_cnt_d;
      phase_q   <= phase_d;
      lcd_d_q   <= lcd_d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    pix_cnt_d = pix_cnt_q;
    phase_d   = phase_q;
    lcd_d_d   = lcd_d_q;
    active_c  = 1'b1;
    request_c = 1'b0;
    done_c    = 1'b0;
    cs_n_c    = 1'b0;
    rs_c      = 1'b1;
    wr_n_c    = 1'b1;

    case (state_q)
      IDLE: begin
        active_c = 1'b0;
        cs_n_c   = 1'b1;
        if (bus.refresh_start_i) begin
          size_d    = bus.display_size_i;
          pix_cnt_d = '0;
`ifdef OGFX_LCD_TE_SYNC_EN
          state_d   = TE_WAIT;
`else
          state_d   = CMD_LO;
          phase_d   = phase_len;
          lcd_d_d   = CMD_RAMWR;
`endif
        end
      end
`ifdef OGFX_LCD_TE_SYNC_EN
      TE_WAIT: begin
        cs_n_c = 1'b1;
        if (te_rise) begin
          state_d = CMD_LO;
          phase_d = phase_len;
          lcd_d_d = CMD_RAMWR;
        end
      end
`endif
      CMD_LO: begin
        rs_c   = 1'b0;
        wr_n_c = 1'b0;
        if (phase_q == 4'd0) begin
          state_d = CMD_HI;
          phase_d = phase_len;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      CMD_HI: begin
        rs_c = 1'b0;
        if (phase_q == 4'd0) begin
          state_d = (size_q == 17'd0) ? DONE : REQ;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      REQ: begin
        request_c = 1'b1;
        state_d   = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (bus.refresh_data_ready_i) begin
          lcd_d_d = bus.refresh_data_i;
          state_d = WR_LO;
          phase_d = phase_len;
        end
      end
      WR_LO: begin
        wr_n_c = 1'b0;
        if (phase_q == 4'd0) begin
          state_d = WR_HI;
          phase_d = phase_len;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      WR_HI: begin
        if (phase_q == 4'd0) begin
          pix_cnt_d = pix_cnt_inc;
          state_d   = (pix_cnt_inc == size_q) ? DONE : REQ;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      DONE: begin
        active_c = 1'b0;
        done_c   = 1'b1;
        cs_n_c   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        active_c = 1'b0;
        cs_n_c   = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  assign bus.refresh_active_o       = active_c;
  assign bus.refresh_data_request_o = request_c;
  assign bus.refresh_done_o         = done_c;
  assign bus.lcd_cs_n_o             = cs_n_c;
  assign bus.lcd_rs_o               = rs_c;
  assign bus.lcd_wr_n_o             = wr_n_c;
  assign bus.lcd_d_o                = lcd_d_q;

endmodule

// File: tb/tb_ogfx_lcd_refresh.sv
// Self-checking bench for ogfx_lcd_refresh: a table of frame scenarios, a mid-frame
// reset sequence and randomized frames checked against a write-list/timing model.
module tb_ogfx_lcd_refresh;

  logic mclk;
  logic puc_rst_n;
  logic lcd_te;

  ogfx_lcd_refresh_if bus ();

  ogfx_lcd_refresh dut (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
`ifdef OGFX_LCD_TE_SYNC_EN
    .lcd_te_i  (lcd_te),
`endif
    .bus       (bus)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic        rs;
    logic [15:0] d;
    int          lo;
    int          hi;
  } wr_t;

  typedef struct {
    int size;
    int cfg;
    int dly;
    bit spur;
    int exp_cycles;
    int exp_req;
  } vec_t;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Packed snapshot of every output that has a defined reset value.
  function automatic longint rst_snapshot();
    return longint'({bus.refresh_active_o, bus.refresh_data_request_o, bus.refresh_done_o,
                     bus.lcd_cs_n_o, bus.lcd_rs_o, bus.lcd_wr_n_o, bus.lcd_d_o});
  endfunction

  localparam longint RST_VALUE = longint'({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000});

  // Run one frame, acting as the pixel backend. The expected LCD write list is built
  // from the frame parameters; abort_req>0 pulls reset during that pixel's WR_LO.
  task automatic run_frame(input int size, input int cfg, input int dly, input bit spur,
                           input int abort_req, input string tag,
                           output int cyc, output int nreq);
    logic [15:0] pix[$];
    wr_t exp_q[$];
    wr_t got_q[$];
    wr_t cur;
    int  w, k, pend, unstable, cs_err, req_wide;
    bit  in_lo, in_hi, done_seen, aborted, spur_rdy, spur_st, req_prev;

    w = (cfg == 0) ? 1 : cfg;
    for (int i = 0; i < size; i++) pix.push_back(16'($urandom));
    exp_q.push_back('{1'b0, 16'h002C, w, w});
    foreach (pix[i]) exp_q.push_back('{1'b1, pix[i], w, w});

    cur = '{1'b0, 16'h0, 0, 0};
    k = 0; pend = -1; unstable = 0; cs_err = 0; req_wide = 0; nreq = 0; cyc = 0;
    in_lo = 0; in_hi = 0; done_seen = 0; aborted = 0; spur_rdy = 0; spur_st = 0; req_prev = 0;

    @(negedge mclk);
    bus.cfg_wr_cycle_i  = 4'(cfg);
    bus.display_size_i  = 17'(size);
    bus.refresh_start_i = 1'b1;
    @(negedge mclk);
    bus.refresh_start_i = 1'b0;
    bus.display_size_i  = 17'($urandom);

`ifdef OGFX_LCD_TE_SYNC_EN
    begin
      int t, rise_at, te_err;
      t = 0; rise_at = -1; te_err = 0;
      while (bus.lcd_cs_n_o && t < 50) begin
        if (!bus.refresh_active_o) te_err++;
        if (t == 10) begin lcd_te = 1'b1; rise_at = t; end
        @(negedge mclk);
        t++;
      end
      lcd_te = 1'b0;
      chk({tag, "_te_active"}, longint'(te_err), 0);
      chk({tag, "_te_latency"}, longint'(t - rise_at), 3);
    end
`endif

    while (!done_seen && !aborted && cyc < 4000) begin
      // Observe this cycle's outputs.
      if (bus.refresh_data_request_o) begin
        nreq++;
        if (req_prev) req_wide++;
      end
      req_prev = bus.refresh_data_request_o;
      if (bus.refresh_active_o && bus.lcd_cs_n_o) cs_err++;

      if (!bus.lcd_cs_n_o && !bus.lcd_wr_n_o) begin
        if (!in_lo) begin
          if (in_hi) got_q.push_back(cur);
          cur = '{bus.lcd_rs_o, bus.lcd_d_o, 1, 0};
          in_lo = 1; in_hi = 0;
        end else begin
          cur.lo++;
          if (bus.lcd_d_o != cur.d || bus.lcd_rs_o != cur.rs) unstable++;
        end
      end else if (in_lo || in_hi) begin
        if (!bus.lcd_cs_n_o && bus.lcd_wr_n_o && !bus.refresh_data_request_o) begin
          in_lo = 0; in_hi = 1; cur.hi++;
          if (bus.lcd_d_o != cur.d || bus.lcd_rs_o != cur.rs) unstable++;
        end else begin
          got_q.push_back(cur);
          in_lo = 0; in_hi = 0;
        end
      end

      if (bus.refresh_done_o) begin
        done_seen = 1;
        chk({tag, "_done_outs"},
            longint'({bus.refresh_active_o, bus.lcd_cs_n_o}), longint'(2'b01));
      end

      if (abort_req > 0 && nreq == abort_req && !bus.lcd_cs_n_o && !bus.lcd_wr_n_o
          && bus.lcd_rs_o) begin
        puc_rst_n = 1'b0;
        #1;
        chk({tag, "_rst_outs"}, rst_snapshot(), RST_VALUE);
        aborted = 1;
      end

      // Drive next cycle's inputs.
      bus.refresh_data_ready_i = 1'b0;
      bus.refresh_start_i      = 1'b0;
      bus.refresh_data_i       = 16'($urandom);
      if (bus.refresh_data_request_o) pend = dly;
      else if (pend > 0) pend--;
      if (pend == 0 && !aborted) begin
        bus.refresh_data_ready_i = 1'b1;
        if (k < pix.size()) bus.refresh_data_i = pix[k];
        k++;
        pend = -1;
      end
      if (spur && !spur_rdy && !bus.lcd_cs_n_o && !bus.lcd_wr_n_o && bus.lcd_rs_o) begin
        bus.refresh_data_ready_i = 1'b1;
        spur_rdy = 1;
      end
      if (spur && !spur_st && bus.refresh_data_request_o) begin
        bus.refresh_start_i = 1'b1;
        bus.display_size_i  = 17'($urandom_range(1, 9));
        spur_st = 1;
      end

      if (!done_seen && !aborted) begin
        @(negedge mclk);
        cyc++;
      end
    end

    bus.refresh_data_ready_i = 1'b0;
    bus.refresh_start_i      = 1'b0;
    if (aborted) return;

    chk({tag, "_done_seen"}, longint'(done_seen), 1);
    chk({tag, "_nwrites"}, longint'(got_q.size()), longint'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_write%0d", tag, i),
          longint'({got_q[i].rs, got_q[i].d, 16'(got_q[i].lo), 16'(got_q[i].hi)}),
          longint'({exp_q[i].rs, exp_q[i].d, 16'(exp_q[i].lo), 16'(exp_q[i].hi)}));
    chk({tag, "_stable"}, longint'(unstable), 0);
    chk({tag, "_cs_low"}, longint'(cs_err), 0);
    chk({tag, "_req_1cyc"}, longint'(req_wide), 0);
  endtask

  vec_t tbl[7];

  initial begin
    int cyc, nreq, sz, cf, dl;
    bit sp;

    // size, cfg W, ready delay, spurious ready/start, done cycle, request pulses
    tbl[0] = '{4, 1, 2, 1'b0, 22, 4};
    tbl[1] = '{0, 1, 1, 1'b0, 2, 0};
    tbl[2] = '{0, 0, 1, 1'b0, 2, 0};
    tbl[3] = '{4, 0, 2, 1'b0, 22, 4};
    tbl[4] = '{2, 3, 1, 1'b0, 22, 2};
    tbl[5] = '{3, 2, 3, 1'b1, 28, 3};
    tbl[6] = '{1, 15, 5, 1'b0, 66, 1};

    lcd_te                   = 1'b0;
    puc_rst_n                = 1'b0;
    bus.refresh_start_i      = 1'b0;
    bus.display_size_i       = '0;
    bus.cfg_wr_cycle_i       = 4'd1;
    bus.refresh_data_i       = '0;
    bus.refresh_data_ready_i = 1'b0;

    repeat (3) @(negedge mclk);
    chk("reset_outs", rst_snapshot(), RST_VALUE);
    puc_rst_n = 1'b1;
    repeat (2) @(negedge mclk);
    chk("idle_after_reset", longint'({bus.refresh_active_o, bus.lcd_cs_n_o}), longint'(2'b01));

    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].size, tbl[i].cfg, tbl[i].dly, tbl[i].spur, 0,
                $sformatf("vec%0d", i), cyc, nreq);
      chk($sformatf("vec%0d_done_cycle", i), longint'(cyc), longint'(tbl[i].exp_cycles));
      chk($sformatf("vec%0d_nreq", i), longint'(nreq), longint'(tbl[i].exp_req));
    end

    // Reset during pixel 2 of 4, then a clean frame must restart from pixel 0.
    run_frame(4, 1, 2, 1'b0, 2, "abort", cyc, nreq);
    @(negedge mclk);
    chk("abort_held", rst_snapshot(), RST_VALUE);
    puc_rst_n = 1'b1;
    repeat (3) @(negedge mclk);
    chk("abort_idle", longint'({bus.refresh_active_o, bus.lcd_cs_n_o}), longint'(2'b01));
    run_frame(4, 1, 2, 1'b0, 0, "restart", cyc, nreq);
    chk("restart_done_cycle", longint'(cyc), 22);
    chk("restart_nreq", longint'(nreq), 4);

    for (int r = 0; r < 20; r++) begin
      sz = int'($urandom_range(0, 6));
      cf = int'($urandom_range(0, 4));
      dl = int'($urandom_range(1, 4));
      sp = 1'($urandom);
      run_frame(sz, cf, dl, sp, 0, $sformatf("rnd%0d", r), cyc, nreq);
      begin
        int w;
        w = (cf == 0) ? 1 : cf;
        chk($sformatf("rnd%0d_done_cycle", r), longint'(cyc),
            longint'(2 * w + sz * (1 + dl + 2 * w)));
      end
      chk($sformatf("rnd%0d_nreq", r), longint'(nreq), longint'(sz));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
